// File: rtl/gol_pkg.sv
// Shared constants and state encoding for the Game-of-Life frame streamer.
// Top-level parameters default to these values so the two stay in step.
package gol_pkg;
    localparam int ROWS      = 16;
    localparam int COLS      = 16;
    localparam int GRID_W    = ROWS * COLS;
    localparam int ROW_IDX_W = $clog2(ROWS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_t;
endpackage

// File: rtl/gol_grid_history.sv
// Holds the captured grid plus two generations of history.
// Classifies the latest capture as still life, period-2 oscillator or extinct.
module gol_grid_history #(
    parameter int GRID_W = gol_pkg::GRID_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [GRID_W-1:0] grid_i,
    output logic [GRID_W-1:0] snapshot_o,
    output logic              still_life_o,
    output logic              osc2_o,
    output logic              extinct_o
);
    logic [GRID_W-1:0] snap_q, snap_d;
    logic [GRID_W-1:0] prev1_q, prev1_d;
    logic [GRID_W-1:0] prev2_q, prev2_d;
    logic              valid_q, valid_d;
    // Number of captures that preceded the one held in snap_q, saturating at 2.
    logic [1:0]        depth_q, depth_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q  <= '0;
            prev1_q <= '0;
            prev2_q <= '0;
            valid_q <= 1'b0;
            depth_q <= 2'd0;
        end else begin
            snap_q  <= snap_d;
            prev1_q <= prev1_d;
            prev2_q <= prev2_d;
            valid_q <= valid_d;
            depth_q <= depth_d;
        end
    end

    always_comb begin
        snap_d  = snap_q;
        prev1_d = prev1_q;
        prev2_d = prev2_q;
        valid_d = valid_q;
        depth_d = depth_q;
        if (load_i) begin
            snap_d  = grid_i;
            prev1_d = snap_q;
            prev2_d = prev1_q;
            valid_d = 1'b1;
            if (!valid_q)
                depth_d = 2'd0;
            else if (depth_q != 2'd2)
                depth_d = depth_q + 2'd1;
        end
    end

    assign snapshot_o   = snap_q;
    assign still_life_o = valid_q && (depth_q != 2'd0) && (snap_q == prev1_q);
    assign osc2_o       = valid_q && (depth_q == 2'd2) && (snap_q == prev2_q) && (snap_q != prev1_q);
    assign extinct_o    = valid_q && (snap_q == '0);
endmodule

// File: rtl/gol_frame_streamer.sv
// Snapshots the Game-of-Life grid on each generation strobe and streams it
// out one row per beat over valid/ready; strobes arriving mid-frame are dropped.
module gol_frame_streamer #(
    parameter int ROWS  = gol_pkg::ROWS,
    parameter int COLS  = gol_pkg::COLS,
    parameter int GEN_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ROWS*COLS-1:0]     q,
    input  logic                     gen_valid,
    output logic [COLS-1:0]          row_data,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic                     row_last,
    output logic                     busy,
    output logic [GEN_W-1:0]         gen_count,
    output logic [7:0]               drop_count,
    output logic                     still_life,
    output logic                     osc2,
    output logic                     extinct
);
    // Handshake: a row transfers on any rising edge where row_valid && row_ready;
    // once row_valid rises, it and the row fields hold until that transfer.
    localparam int                IDX_W    = $clog2(ROWS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);

    gol_pkg::stream_state_t state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [GEN_W-1:0]       gen_q, gen_d;
    logic [7:0]             drop_q, drop_d;
    logic                   capture;
    logic [ROWS*COLS-1:0]   snapshot;
    logic [COLS-1:0]        row_sel;

    assign capture = (state_q == gol_pkg::IDLE) && gen_valid;

    gol_grid_history #(.GRID_W(ROWS * COLS)) u_history (
        .clk          (clk),
        .reset        (reset),
        .load_i       (capture),
        .grid_i       (q),
        .snapshot_o   (snapshot),
        .still_life_o (still_life),
        .osc2_o       (osc2),
        .extinct_o    (extinct)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= gol_pkg::IDLE;
            idx_q   <= '0;
            gen_q   <= '0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gen_q   <= gen_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gen_d   = gen_q;
        drop_d  = drop_q;
        case (state_q)
            gol_pkg::IDLE: begin
                if (gen_valid) begin
                    state_d = gol_pkg::SEND;
                    idx_d   = '0;
                    gen_d   = gen_q + GEN_W'(1);
                end
            end
            gol_pkg::SEND: begin
                if (row_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = gol_pkg::IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                if (gen_valid && (drop_q != 8'hFF))
                    drop_d = drop_q + 8'd1;
            end
            default: state_d = gol_pkg::IDLE;
        endcase
    end

    // Row 0 sits in the most significant COLS bits of the grid.
    always_comb begin
        row_sel = snapshot[(ROWS - int'(idx_q)) * COLS - 1 -: COLS];
    end

    assign busy       = (state_q == gol_pkg::SEND);
    assign row_valid  = busy;
    assign row_idx    = idx_q;
    assign row_last   = busy && (idx_q == LAST_IDX);
    assign row_data   = busy ? row_sel : '0;
    assign gen_count  = gen_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_gol_frame_streamer.sv
// Directed bench for gol_frame_streamer: expected row beats are queued as frames
// are issued and a negedge monitor pops and compares every accepted beat.
module tb_gol_frame_streamer;
    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] q;
    logic         gen_valid;
    logic [15:0]  row_data;
    logic [3:0]   row_idx;
    logic         row_valid;
    logic         row_ready;
    logic         row_last;
    logic         busy;
    logic [15:0]  gen_count;
    logic [7:0]   drop_count;
    logic         still_life;
    logic         osc2;
    logic         extinct;

    int n_checks = 0;
    int n_errors = 0;

    // Each entry: {row_idx[3:0], row_last, row_data[15:0]}
    logic [20:0] exp_q[$];

    logic [255:0] vb, hb, blk, zero, bp;

    gol_frame_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .q          (q),
        .gen_valid  (gen_valid),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_last   (row_last),
        .busy       (busy),
        .gen_count  (gen_count),
        .drop_count (drop_count),
        .still_life (still_life),
        .osc2       (osc2),
        .extinct    (extinct)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [255:0] set_row(input logic [255:0] g, input int r, input logic [15:0] v);
        logic [255:0] t;
        t = g;
        t[(16 - r) * 16 - 1 -: 16] = v;
        return t;
    endfunction

    task automatic push_frame(input logic [255:0] g, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            logic [3:0] ri;
            ri = 4'(r);
            exp_q.push_back({ri, (r == 15), g[(16 - r) * 16 - 1 -: 16]});
        end
    endtask

    // Drives one-cycle gen_valid; returns #1 after the capture edge.
    task automatic gen_pulse(input logic [255:0] g, input int nrows);
        @(posedge clk); #1;
        q = g;
        gen_valid = 1'b1;
        push_frame(g, nrows);
        @(posedge clk); #1;
        gen_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input bit rand_ready);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            if (rand_ready)
                row_ready = (n > 150) ? 1'b1 : 1'(($urandom_range(0, 1)));
            @(posedge clk); #1;
            n++;
        end
        row_ready = 1'b1;
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
        end
    endtask

    // Monitor / scoreboard
    logic [20:0] stall_val;
    bit          stalled   = 1'b0;
    bit          last_seen = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            stalled   = 1'b0;
            last_seen = 1'b0;
        end else begin
            if (last_seen) begin
                check("busy_after_last", {31'd0, busy}, 32'd0);
                last_seen = 1'b0;
            end
            if (stalled) begin
                if (!row_valid) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL valid_drop: row_valid 0 while stalled, required 1");
                end else begin
                    check("stall_stable", {11'd0, row_idx, row_last, row_data}, {11'd0, stall_val});
                end
            end
            stalled   = row_valid && !row_ready;
            stall_val = {row_idx, row_last, row_data};
            if (row_valid && row_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got idx %0d data %0h, none expected", row_idx, row_data);
                end else begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    check("row_beat", {11'd0, row_idx, row_last, row_data}, {11'd0, e});
                    if (e[16]) last_seen = 1'b1;
                end
            end
        end
    end

    task automatic check_flags(input string name, input logic [2:0] want);
        check(name, {29'd0, still_life, osc2, extinct}, {29'd0, want});
    endtask

    initial begin
        vb = '0; vb = set_row(vb, 7, 16'h0080); vb = set_row(vb, 8, 16'h0080); vb = set_row(vb, 9, 16'h0080);
        hb = '0; hb = set_row(hb, 8, 16'h01C0);
        blk = '0; blk = set_row(blk, 4, 16'h0C00); blk = set_row(blk, 5, 16'h0C00);
        zero = '0;
        bp = '0;
        for (int r = 0; r < 16; r++) bp = set_row(bp, r, 16'hA5A5 ^ (16'(r) * 16'h0111));

        reset = 1'b1; q = '0; gen_valid = 1'b0; row_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row_valid", {31'd0, row_valid}, 32'd0);
        check("rst_row_last",  {31'd0, row_last},  32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_row_idx",   {28'd0, row_idx},   32'd0);
        check("rst_row_data",  {16'd0, row_data},  32'd0);
        check("rst_gen_count", {16'd0, gen_count}, 32'd0);
        check("rst_drop",      {24'd0, drop_count}, 32'd0);
        check_flags("rst_flags", 3'b000);
        reset = 1'b0;

        // Blinker: vertical, horizontal, vertical
        gen_pulse(vb, 16);
        check("lat_row_valid", {31'd0, row_valid}, 32'd1);
        check("lat_row_idx",   {28'd0, row_idx},   32'd0);
        check("lat_busy",      {31'd0, busy},      32'd1);
        check("gen1_count",    {16'd0, gen_count}, 32'd1);
        check_flags("blinker_gen1", 3'b000);
        wait_idle(40, 1'b0);
        gen_pulse(hb, 16);
        check_flags("blinker_gen2", 3'b000);
        wait_idle(40, 1'b0);
        gen_pulse(vb, 16);
        check_flags("blinker_gen3", 3'b010);
        wait_idle(40, 1'b0);

        // Block twice
        gen_pulse(blk, 16);
        check_flags("block_1", 3'b000);
        wait_idle(40, 1'b0);
        gen_pulse(blk, 16);
        check_flags("block_2", 3'b100);
        wait_idle(40, 1'b0);

        // Empty grid twice
        gen_pulse(zero, 16);
        check_flags("zero_1", 3'b001);
        wait_idle(40, 1'b0);
        gen_pulse(zero, 16);
        check_flags("zero_2", 3'b101);
        wait_idle(40, 1'b0);

        // Backpressure
        gen_pulse(bp, 16);
        check_flags("bp_flags", 3'b000);
        wait_idle(400, 1'b1);
        check("bp_busy_done", {31'd0, busy}, 32'd0);
        check("bp_gen_count", {16'd0, gen_count}, 32'd8);
        check("drop_none_yet", {24'd0, drop_count}, 32'd0);

        // gen_valid held high for 40 cycles: captures at 0, 17, 34
        push_frame(bp, 16); push_frame(bp, 16); push_frame(bp, 16);
        q = bp;
        gen_valid = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        gen_valid = 1'b0;
        wait_idle(40, 1'b0);
        check("hold_gen_count", {16'd0, gen_count}, 32'd11);
        check("hold_drop",      {24'd0, drop_count}, 32'd37);
        check_flags("hold_flags", 3'b100);

        // Reset during row 5
        gen_pulse(vb, 5);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_row_idx", {28'd0, row_idx}, 32'd5);
        row_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_row_valid", {31'd0, row_valid}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        check("mid_rst_row_idx",   {28'd0, row_idx},   32'd0);
        check("mid_rst_row_data",  {16'd0, row_data},  32'd0);
        check("mid_rst_row_last",  {31'd0, row_last},  32'd0);
        check("mid_rst_gen_count", {16'd0, gen_count}, 32'd0);
        check("mid_rst_drop",      {24'd0, drop_count}, 32'd0);
        check_flags("mid_rst_flags", 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;
        row_ready = 1'b1;
        gen_pulse(vb, 16);
        check("post_rst_row_idx",   {28'd0, row_idx},   32'd0);
        check("post_rst_gen_count", {16'd0, gen_count}, 32'd1);
        check_flags("post_rst_flags", 3'b000);
        wait_idle(40, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/gol_frame_streamer.md
# gol_frame_streamer

Downstream consumer of the Game-of-Life datapath's 256-bit next-state grid `q`. On each generation strobe it snapshots the 16x16 grid, classifies it against the two previous snapshots (still life, period-2 oscillator, extinction), and streams it out one 16-bit row at a time over a valid/ready handshake to a display or logging sink. Generations arriving while a frame is still streaming are dropped and counted.

## Interface
Parameters:
- `ROWS`, 16, grid rows
- `COLS`, 16, grid columns; grid width is ROWS*COLS
- `GEN_W`, 16, generation counter width

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `q`  in  ROWS*COLS  current grid from datapath; row r = q[(ROWS-r)*COLS-1 -: COLS], row 0 is MSBs
- `gen_valid`  in  1  q holds a new generation this cycle
- `row_data`  out  COLS  row being offered
- `row_idx`  out  $clog2(ROWS)  index of offered row
- `row_valid`  out  1  row_data/row_idx/row_last valid
- `row_ready`  in  1  sink accepts row when row_valid && row_ready
- `row_last`  out  1  high with row ROWS-1
- `busy`  out  1  frame captured and not fully streamed
- `gen_count`  out  GEN_W  captured generations, wraps
- `drop_count`  out  8  dropped generations, saturates at 255
- `still_life`, `osc2`, `extinct`  out  1 each  classification of the latest captured frame

## Operation
- FSM states: IDLE, SEND. Reset -> IDLE.
- IDLE & gen_valid: capture q into snapshot, shift history (prev2 <= prev1 <= old snapshot), update flags, gen_count += 1, -> SEND with row_idx = 0.
- SEND: row_valid = 1, row_data = snapshot row row_idx. On accept: row_idx += 1; on accept of row ROWS-1 -> IDLE.
- gen_valid while in SEND (including the cycle the last row is accepted): frame ignored, drop_count += 1 (saturating); snapshot, history, flags unchanged.
- still_life = (q == prev1) and at least one prior capture.
- osc2 = (q == prev2) and (q != prev1) and at least two prior captures.
- extinct = (q == 0); extinct and still_life may both be 1.
- Flags hold until next capture. History depth counter saturates at 2.
- busy = (state == SEND).

## Timing
- Reset values: row_valid 0, row_last 0, busy 0, row_idx 0, row_data 0, gen_count 0, drop_count 0, all flags 0, history invalid.
- Capture at edge ending gen_valid cycle; flags, gen_count valid and row 0 offered the following cycle (latency 1).
- With row_ready held high: ROWS consecutive row beats, back-to-back.
- row_data/row_idx/row_last stable while row_valid && !row_ready; row_valid never drops without acceptance except on reset.
- After last accept: one IDLE cycle minimum before the next capture can be taken (gen_valid in that IDLE cycle is captured).
- Reset mid-frame: immediate return to IDLE, stream aborted, all state cleared.

## Structure
- Package `gol_pkg`: ROWS, COLS, GRID_W, ROW_IDX_W constants, `stream_state_t` enum {IDLE, SEND}.
- Sub-module `gol_grid_history`: holds snapshot/prev1/prev2 and depth counter, produces still_life/osc2/extinct on a load strobe. Top holds FSM, counters, row mux.

## Test plan
- Blinker (vertical 3-cell at rows 7-9, col 8), row_ready=1, gen_valid every 17 cycles: gen 1 flags 0; gen 2 flags 0; gen 3 osc2=1, still_life=0; rows 0..15 match grid, row_last only on row_idx 15.
- Block (2x2 at rows 4-5, cols 4-5) twice: second capture still_life=1, osc2=0, extinct=0.
- All-zero grid twice: first extinct=1 still_life=0; second extinct=1 still_life=1.
- Backpressure: row_ready toggled pseudo-randomly; row_data stable while stalled, 16 beats in order, busy drops after last accept.
- gen_valid held high 40 cycles with row_ready=1: captures at cycles 0 and 17, 34; gen_count=3, drop_count=37.
- Reset asserted during row 5 of a frame: outputs return to reset values asynchronously, next gen_valid after release restarts at row_idx 0 with flags 0.
